// File: rtl/uart_tx_fifo_nco.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_fifo_nco
// Purpose  : UART transmitter with a small write FIFO and an NCO baud
//            generator whose increment can be reloaded at run time.
//            Queued characters are sent back-to-back with no idle gap.
// Ports    : clk, rst        - clock / synchronous active-high reset
//            wr_en, wr_data  - queue one character per cycle
//            inc_load,
//            inc_value       - set pending NCO increment (0 ignored)
//            txd             - serial output, idle high
//            busy            - a frame is on the line
//            full, empty,
//            level           - FIFO status / occupancy
//            tx_done         - pulse in the cycle the last stop bit ends
//            ovf             - pulse the cycle after a dropped write
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_fifo_nco #(
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 2,
    parameter int FIFO_DEPTH   = 4,
    parameter int NCO_W        = 16,
    parameter int DEFAULT_BDR  = 115200,
    parameter int SYS_CLK_DIV2 = 100_000_000
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          wr_en,
    input  logic [DATA_BITS-1:0]          wr_data,
    input  logic                          inc_load,
    input  logic [NCO_W-1:0]              inc_value,
    output logic                          txd,
    output logic                          busy,
    output logic                          full,
    output logic                          empty,
    output logic [$clog2(FIFO_DEPTH):0]   level,
    output logic                          tx_done,
    output logic                          ovf
);

    localparam int c_par_bits = (PARITY != 0) ? 1 : 0;
    localparam int c_frame_w  = 1 + DATA_BITS + c_par_bits + STOP_BITS;
    localparam int c_ptr_w    = $clog2(FIFO_DEPTH);
    localparam int c_lvl_w    = c_ptr_w + 1;
    localparam int c_cnt_w    = $clog2(c_frame_w);

    // Increment computed 64 bits wide, then truncated to the accumulator.
    localparam logic [63:0]        c_inc_wide    = (64'(DEFAULT_BDR) << NCO_W) / 64'(SYS_CLK_DIV2);
    localparam logic [NCO_W-1:0]   c_default_inc = c_inc_wide[NCO_W-1:0];

    localparam logic [c_cnt_w-1:0] c_last_bit = c_cnt_w'(c_frame_w - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);
    localparam logic [c_ptr_w-1:0] c_ptr_one  = c_ptr_w'(1);
    localparam logic [c_lvl_w-1:0] c_lvl_one  = c_lvl_w'(1);
    localparam logic [c_lvl_w-1:0] c_lvl_full = c_lvl_w'(FIFO_DEPTH);

    localparam logic [0:0] c_IDLE = 1'b0;
    localparam logic [0:0] c_SEND = 1'b1;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [DATA_BITS-1:0] r_mem [FIFO_DEPTH];
    logic [c_ptr_w-1:0]   r_wr_ptr, r_rd_ptr;
    logic [c_lvl_w-1:0]   r_level;
    logic                 r_full, r_empty, r_ovf;
    logic [0:0]           r_state;
    logic [c_frame_w-1:0] r_shift;
    logic [c_cnt_w-1:0]   r_bit_cnt;
    logic [NCO_W-1:0]     r_acc, r_active_inc, r_pending_inc;
    logic                 r_txd, r_busy;

    // ------------------------------------------------------------------
    // Combinational
    // ------------------------------------------------------------------
    logic                 w_push, w_pop, w_tick, w_last, w_done;
    logic [NCO_W:0]       w_sum;
    logic [DATA_BITS-1:0] w_head;
    logic [c_frame_w-1:0] w_frame;

    logic [c_lvl_w-1:0]   w_level_nxt;
    logic [0:0]           w_state_nxt;
    logic [c_frame_w-1:0] w_shift_nxt;
    logic [c_cnt_w-1:0]   w_bit_cnt_nxt;
    logic [NCO_W-1:0]     w_acc_nxt, w_active_inc_nxt;
    logic                 w_busy_nxt;

    // Writes are qualified only by the registered full flag, so a pop in
    // the same cycle never rescues a write that arrives while full.
    assign w_push = wr_en & ~r_full;

    assign w_sum  = {1'b0, r_acc} + {1'b0, r_active_inc};
    assign w_tick = (r_state == c_SEND) & w_sum[NCO_W];
    assign w_last = (r_bit_cnt == c_last_bit);
    assign w_done = w_tick & w_last;

    // A frame starts from IDLE, or directly on the final stop-bit tick so
    // the next start bit follows without an idle gap.
    assign w_pop  = ~r_empty & ((r_state == c_IDLE) | w_done);
    assign w_head = r_mem[r_rd_ptr];

    generate
        if (PARITY != 0) begin : g_parity
            logic w_par_bit;
            assign w_par_bit = (PARITY == 2) ? ~(^w_head) : (^w_head);
            assign w_frame   = {{STOP_BITS{1'b1}}, w_par_bit, w_head, 1'b0};
        end else begin : g_no_parity
            assign w_frame   = {{STOP_BITS{1'b1}}, w_head, 1'b0};
        end
    endgenerate

    always_comb begin
        w_level_nxt = r_level;
        if (w_push && !w_pop) begin
            w_level_nxt = r_level + c_lvl_one;
        end else if (!w_push && w_pop) begin
            w_level_nxt = r_level - c_lvl_one;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_shift_nxt      = r_shift;
        w_bit_cnt_nxt    = r_bit_cnt;
        w_acc_nxt        = r_acc;
        w_active_inc_nxt = r_active_inc;
        w_busy_nxt       = r_busy;
        if (w_pop) begin
            w_shift_nxt      = w_frame;
            w_bit_cnt_nxt    = '0;
            w_acc_nxt        = '0;
            w_active_inc_nxt = r_pending_inc;
            w_state_nxt      = c_SEND;
            w_busy_nxt       = 1'b1;
        end else if (r_state == c_SEND) begin
            w_acc_nxt = w_sum[NCO_W-1:0];
            if (w_tick) begin
                if (!w_last) begin
                    w_shift_nxt   = {1'b1, r_shift[c_frame_w-1:1]};
                    w_bit_cnt_nxt = r_bit_cnt + c_cnt_one;
                end else begin
                    w_shift_nxt = '1;
                    w_state_nxt = c_IDLE;
                    w_busy_nxt  = 1'b0;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Sequential
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_level       <= '0;
            r_full        <= 1'b0;
            r_empty       <= 1'b1;
            r_ovf         <= 1'b0;
            r_state       <= c_IDLE;
            r_shift       <= '1;
            r_bit_cnt     <= '0;
            r_acc         <= '0;
            r_active_inc  <= c_default_inc;
            r_pending_inc <= c_default_inc;
            r_txd         <= 1'b1;
            r_busy        <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_one;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_one;
            end
            r_level <= w_level_nxt;
            r_full  <= (w_level_nxt == c_lvl_full);
            r_empty <= (w_level_nxt == '0);
            r_ovf   <= wr_en & r_full;
            if (inc_load && (inc_value != '0)) begin
                r_pending_inc <= inc_value;
            end
            r_state      <= w_state_nxt;
            r_shift      <= w_shift_nxt;
            r_bit_cnt    <= w_bit_cnt_nxt;
            r_acc        <= w_acc_nxt;
            r_active_inc <= w_active_inc_nxt;
            r_busy       <= w_busy_nxt;
            r_txd        <= w_shift_nxt[0];
        end
    end

    assign txd   = r_txd;
    assign busy  = r_busy;
    assign full  = r_full;
    assign empty = r_empty;
    assign level = r_level;
    assign ovf   = r_ovf;
    // The frame-end strobe is combinational with the tick; masking it with
    // rst keeps a reset that lands on the final tick from reporting a frame.
    assign tx_done = w_done & ~rst;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_fifo_nco.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_fifo_nco
// Purpose  : Directed bench for uart_tx_fifo_nco. Three instances cover the
//            8N2 default, 7E1 and 8O1 frame formats.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_fifo_nco;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  wr_en;
    logic [7:0]  wr_data;
    logic        inc_load;
    logic [15:0] inc_value;

    logic [2:0]  txd_v, busy_v, full_v, empty_v, done_v, ovf_v;
    logic [2:0]  level_v [3];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    uart_tx_fifo_nco u_dut_8n2 (
        .clk(clk), .rst(rst), .wr_en(wr_en[0]), .wr_data(wr_data),
        .inc_load(inc_load), .inc_value(inc_value),
        .txd(txd_v[0]), .busy(busy_v[0]), .full(full_v[0]), .empty(empty_v[0]),
        .level(level_v[0]), .tx_done(done_v[0]), .ovf(ovf_v[0])
    );

    uart_tx_fifo_nco #(.DATA_BITS(7), .PARITY(1), .STOP_BITS(1)) u_dut_7e1 (
        .clk(clk), .rst(rst), .wr_en(wr_en[1]), .wr_data(wr_data[6:0]),
        .inc_load(inc_load), .inc_value(inc_value),
        .txd(txd_v[1]), .busy(busy_v[1]), .full(full_v[1]), .empty(empty_v[1]),
        .level(level_v[1]), .tx_done(done_v[1]), .ovf(ovf_v[1])
    );

    uart_tx_fifo_nco #(.DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u_dut_8o1 (
        .clk(clk), .rst(rst), .wr_en(wr_en[2]), .wr_data(wr_data),
        .inc_load(inc_load), .inc_value(inc_value),
        .txd(txd_v[2]), .busy(busy_v[2]), .full(full_v[2]), .empty(empty_v[2]),
        .level(level_v[2]), .tx_done(done_v[2]), .ovf(ovf_v[2])
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at the negedge of the first start-bit cycle; checks every cycle
    // of the frame and returns at the negedge of the cycle after it.
    task automatic check_frame(input int sel, input string tag, input logic [15:0] bits,
                               input int n, input int per);
        for (int i = 0; i < n; i++) begin
            for (int j = 0; j < per; j++) begin
                chk($sformatf("%s txd bit%0d", tag, i), 32'(txd_v[sel]), 32'(bits[i]));
                chk($sformatf("%s busy bit%0d", tag, i), 32'(busy_v[sel]), 32'd1);
                chk($sformatf("%s tx_done bit%0d", tag, i), 32'(done_v[sel]),
                    32'((i == n - 1) && (j == per - 1)));
                @(negedge clk);
            end
        end
    endtask

    task automatic check_idle(input int sel, input string tag);
        chk({tag, " idle txd"}, 32'(txd_v[sel]), 32'd1);
        chk({tag, " idle busy"}, 32'(busy_v[sel]), 32'd0);
        chk({tag, " idle empty"}, 32'(empty_v[sel]), 32'd1);
        chk({tag, " idle tx_done"}, 32'(done_v[sel]), 32'd0);
    endtask

    initial begin
        rst       = 1'b1;
        wr_en     = '0;
        wr_data   = '0;
        inc_load  = 1'b0;
        inc_value = '0;
        repeat (3) @(negedge clk);

        // Reset state of all three instances
        for (int s = 0; s < 3; s++) begin
            chk($sformatf("rst txd%0d", s), 32'(txd_v[s]), 32'd1);
            chk($sformatf("rst busy%0d", s), 32'(busy_v[s]), 32'd0);
            chk($sformatf("rst full%0d", s), 32'(full_v[s]), 32'd0);
            chk($sformatf("rst empty%0d", s), 32'(empty_v[s]), 32'd1);
            chk($sformatf("rst level%0d", s), 32'(level_v[s]), 32'd0);
            chk($sformatf("rst tx_done%0d", s), 32'(done_v[s]), 32'd0);
            chk($sformatf("rst ovf%0d", s), 32'(ovf_v[s]), 32'd0);
        end
        rst       = 1'b0;
        inc_load  = 1'b1;
        inc_value = 16'h4000;
        @(negedge clk);
        inc_load  = 1'b0;

        // 8N2, 0xA5: 0,1,0,1,0,0,1,0,1,1,1 at 4 cycles per bit
        wr_data  = 8'hA5;
        wr_en[0] = 1'b1;
        @(negedge clk);
        wr_en[0] = 1'b0;
        chk("8n2 empty T+1", 32'(empty_v[0]), 32'd0);
        chk("8n2 busy T+1", 32'(busy_v[0]), 32'd0);
        chk("8n2 level T+1", 32'(level_v[0]), 32'd1);
        chk("8n2 txd T+1", 32'(txd_v[0]), 32'd1);
        @(negedge clk);
        check_frame(0, "8n2 A5", 16'h074A, 11, 4);
        check_idle(0, "8n2");

        // 7E1, 0x55: 0,1,0,1,0,1,0,1,0,1
        wr_data  = 8'h55;
        wr_en[1] = 1'b1;
        @(negedge clk);
        wr_en[1] = 1'b0;
        @(negedge clk);
        check_frame(1, "7e1 55", 16'h02AA, 10, 4);
        check_idle(1, "7e1");

        // 8O1, 0x01 (parity 0) then 0x03 (parity 1), back-to-back
        wr_data  = 8'h01;
        wr_en[2] = 1'b1;
        @(negedge clk);
        wr_data  = 8'h03;
        @(negedge clk);
        wr_en[2] = 1'b0;
        check_frame(2, "8o1 01", 16'h0402, 11, 4);
        check_frame(2, "8o1 03", 16'h0606, 11, 4);
        check_idle(2, "8o1");

        // Increment change mid-frame: 0x3C keeps 4-cycle bits, 0x5A uses 8
        wr_data  = 8'h3C;
        wr_en[0] = 1'b1;
        @(negedge clk);
        wr_data  = 8'h5A;
        @(negedge clk);
        wr_en[0]  = 1'b0;
        inc_load  = 1'b1;
        inc_value = 16'h2000;
        check_frame(0, "inc old 3C", 16'h0678, 11, 4);
        check_frame(0, "inc new 5A", 16'h06B4, 11, 8);
        inc_load = 1'b0;
        check_idle(0, "inc");

        // A zero increment load is ignored; 0x2000 stays in force
        inc_load  = 1'b1;
        inc_value = 16'h0000;
        @(negedge clk);
        inc_load  = 1'b0;

        // FIFO fill and overflow: 0x11..0x15, then 0x16 while full
        wr_data  = 8'h11;
        wr_en[0] = 1'b1;
        @(negedge clk);
        chk("fill level after 1", 32'(level_v[0]), 32'd1);
        chk("fill empty after 1", 32'(empty_v[0]), 32'd0);
        wr_data = 8'h12;
        @(negedge clk);
        chk("fill level after pop", 32'(level_v[0]), 32'd1);
        chk("fill busy start", 32'(busy_v[0]), 32'd1);
        chk("fill txd start", 32'(txd_v[0]), 32'd0);
        wr_data = 8'h13;
        @(negedge clk);
        chk("fill level 2", 32'(level_v[0]), 32'd2);
        wr_data = 8'h14;
        @(negedge clk);
        chk("fill level 3", 32'(level_v[0]), 32'd3);
        chk("fill full at 3", 32'(full_v[0]), 32'd0);
        wr_data = 8'h15;
        @(negedge clk);
        chk("fill level 4", 32'(level_v[0]), 32'd4);
        chk("fill full at 4", 32'(full_v[0]), 32'd1);
        chk("fill ovf 5th write", 32'(ovf_v[0]), 32'd0);
        wr_data = 8'h16;
        @(negedge clk);
        chk("ovf pulse", 32'(ovf_v[0]), 32'd1);
        chk("ovf level held", 32'(level_v[0]), 32'd4);
        chk("ovf full held", 32'(full_v[0]), 32'd1);
        wr_en[0] = 1'b0;
        @(negedge clk);
        chk("ovf one cycle", 32'(ovf_v[0]), 32'd0);
        repeat (82) @(negedge clk);
        chk("fill first done", 32'(done_v[0]), 32'd1);
        chk("fill first stop", 32'(txd_v[0]), 32'd1);
        chk("fill level before reload", 32'(level_v[0]), 32'd4);
        @(negedge clk);
        chk("fill level after reload", 32'(level_v[0]), 32'd3);
        chk("fill full after reload", 32'(full_v[0]), 32'd0);
        check_frame(0, "fifo 12", 16'h0624, 11, 8);
        check_frame(0, "fifo 13", 16'h0626, 11, 8);
        check_frame(0, "fifo 14", 16'h0628, 11, 8);
        check_frame(0, "fifo 15", 16'h062A, 11, 8);
        check_idle(0, "fifo");
        chk("fifo level drained", 32'(level_v[0]), 32'd0);

        // Reset mid-frame with two entries queued
        wr_data  = 8'h77;
        wr_en[0] = 1'b1;
        @(negedge clk);
        wr_data  = 8'h88;
        @(negedge clk);
        wr_data  = 8'h99;
        @(negedge clk);
        wr_en[0] = 1'b0;
        chk("rstmid level queued", 32'(level_v[0]), 32'd2);
        repeat (40) @(negedge clk);
        chk("rstmid busy before", 32'(busy_v[0]), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rstmid txd", 32'(txd_v[0]), 32'd1);
        chk("rstmid busy", 32'(busy_v[0]), 32'd0);
        chk("rstmid level", 32'(level_v[0]), 32'd0);
        chk("rstmid empty", 32'(empty_v[0]), 32'd1);
        chk("rstmid full", 32'(full_v[0]), 32'd0);
        chk("rstmid tx_done", 32'(done_v[0]), 32'd0);
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            check_idle(0, "rstmid quiet");
        end

        // Default increment after reset: 115200*65536/1e8 -> 75,
        // start bit lasts ceil(65536/75) = 874 cycles
        wr_data  = 8'h01;
        wr_en[0] = 1'b1;
        @(negedge clk);
        wr_en[0] = 1'b0;
        @(negedge clk);
        chk("dflt start txd", 32'(txd_v[0]), 32'd0);
        chk("dflt start busy", 32'(busy_v[0]), 32'd1);
        repeat (873) @(negedge clk);
        chk("dflt start last cycle", 32'(txd_v[0]), 32'd0);
        @(negedge clk);
        chk("dflt data bit0", 32'(txd_v[0]), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_tx_fifo_nco.md
# uart_tx_fifo_nco

Parametrised UART transmitter for the HANDMADE peripheral set. It supports configurable data width, parity mode and stop-bit count, and its NCO baud generator takes an increment reloadable at run time. A small write FIFO lets the host queue characters, which are sent back-to-back with no idle gap. It sits between a register/bus front end and the board TXD pin.

## Interface
- DATA_BITS, 8 — data bits per frame, legal 5..9, sent LSB first
- PARITY, 0 — 0 none, 1 even, 2 odd
- STOP_BITS, 2 — 1 or 2
- FIFO_DEPTH, 4 — entries, power of 2, ≥2
- NCO_W, 16 — accumulator width
- DEFAULT_BDR, 115200 — baud rate after reset
- SYS_CLK_DIV2, 100_000_000 — clock frequency in Hz used for the increment computation
- Derived: DEFAULT_INC = DEFAULT_BDR·2^NCO_W / SYS_CLK_DIV2, truncated to NCO_W bits
- Derived: N = 1 + DATA_BITS + (PARITY≠0) + STOP_BITS, the frame length in bits
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- wr_en  in  1  write strobe, one entry per cycle
- wr_data  in  DATA_BITS  character to queue
- inc_load  in  1  strobe: latch inc_value as the pending increment
- inc_value  in  NCO_W  new NCO increment
- txd  out  1  serial output, idle high
- busy  out  1  high while a frame is on the line
- full  out  1  FIFO holds FIFO_DEPTH entries
- empty  out  1  FIFO holds 0 entries
- level  out  clog2(FIFO_DEPTH)+1  FIFO occupancy
- tx_done  out  1  one-cycle pulse at the end of each frame
- ovf  out  1  one-cycle pulse when a write is dropped

## Operation
- **Reset values:** txd=1, busy=0, full=0, empty=1, level=0, tx_done=0, ovf=0, FIFO flushed, pending_inc=active_inc=DEFAULT_INC, acc=0, state IDLE.
- **FIFO writes:** wr_en is accepted iff full=0, decided on the registered full flag. A write while full is dropped and pulses ovf next cycle, even if a pop happens in the same cycle.
- **FIFO occupancy:** a simultaneous accepted write and pop leaves level unchanged. Pop occurs only when empty=0.
- **Increment loading:**
  - inc_load with inc_value≠0 sets pending_inc; inc_load with inc_value=0 is ignored.
  - active_inc ← pending_inc only at frame start, so a frame is never altered mid-flight.
- **Frame content:** shift register = {STOP_BITS×1, parity, data, 0}, shifted out LSB first.
  - Even parity = XOR of data bits; odd parity = XNOR of data bits.
- **NCO:** each cycle in SEND, {carry, acc} ← acc + active_inc, computed NCO_W+1 bits wide. The tick is the carry bit of that sum, combinational and same cycle. acc clears to 0 at every frame start.
- **FSM:**
  - IDLE: if empty=0 → pop, load the shift register, bit_cnt←0, acc←0, active_inc←pending_inc, busy←1, go to SEND.
  - SEND, on tick with bit_cnt<N-1: shift right, fill with 1, bit_cnt+1.
  - SEND, on tick with bit_cnt=N-1: tx_done pulses.
    - If empty=0: reload the next frame on the same edge (back-to-back start bit, no gap, busy stays 1).
    - Otherwise: txd=1, busy←0, go to IDLE.
- **Output:** txd is a registered copy of shift[0]; no glitches.

## Timing
- Write to idle, empty transmitter in cycle T:
  - empty falls at T+1.
  - FSM pops at edge T+1, so busy=1 and txd=0 from T+2.
- Bit period = ceil((2^NCO_W − acc_at_bit_start)/active_inc) cycles. With active_inc=2^(NCO_W−2), every bit lasts exactly 4 cycles.
- tx_done is asserted in the cycle the final stop bit's tick occurs; the next start bit appears at the following edge.
- Reset mid-frame: at the next edge txd=1, busy=0, FIFO is empty, and no tx_done is generated.
- Boundaries:
  - FIFO pointers wrap modulo FIFO_DEPTH.
  - level reaches FIFO_DEPTH exactly when full=1.
  - acc wraps modulo 2^NCO_W.

## Test plan
- **8N2 frame:** defaults; inc_load 0x4000, write 0xA5.
  - Required txd: 0,1,0,1,0,0,1,0,1,1,1, each held 4 cycles (44 cycles total).
  - tx_done pulses once, then busy=0.
- **7E1 frame:** DATA_BITS=7, PARITY=1, STOP_BITS=1, inc 0x4000, write 0x55.
  - Required txd: 0,1,0,1,0,1,0,1,0,1; parity bit = 0.
- **8O1 frame:** DATA_BITS=8, PARITY=2, STOP_BITS=1, write 0x01; parity bit = 0.
  - Write 0x03; parity bit = 1.
- **FIFO fill and overflow:** write 5 bytes (0x11..0x15) in consecutive cycles while idle.
  - The first byte is popped as soon as transmission starts; then 4 remain and full=1.
  - The 5th write pulses ovf only if it hits full; check level against the expected count.
  - Frames follow back-to-back with no high gap between a stop bit and the next start bit.
- **Increment change mid-frame:** inc_load 0x2000 during a frame sent at 0x4000.
  - The current frame keeps 4-cycle bits; the next frame uses 8-cycle bits.
- **Reset mid-frame:** assert rst at bit 5 with 2 entries queued.
  - Next edge: txd=1, busy=0, level=0, empty=1.
  - No further activity until the next write.
